// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: key-schedule constants, FSM state type and the
// byte/word transforms (S-box, SubWord, RotWord, Rcon) used by the key schedule.
package aes_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    logic [7:0] s;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round_key.sv
// One backward step of the AES-128 key schedule: recovers round key r-1 from
// round key r. The recovered w3 feeding SubWord is the long path.
module aes_inv_round_key
  import aes_pkg::*;
(
  input  logic [KW-1:0] key_next,
  input  logic [3:0]    round,
  output logic [KW-1:0] key_prev
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w0_n, w1_n, w2_n, w3_n;

  assign w0_n = key_next[127:96];
  assign w1_n = key_next[95:64];
  assign w2_n = key_next[63:32];
  assign w3_n = key_next[31:0];

  assign w3 = w3_n ^ w2_n;
  assign w2 = w2_n ^ w1_n;
  assign w1 = w1_n ^ w0_n;
  assign w0 = w0_n ^ sub_word(rot_word(w3)) ^ rcon(round);

  assign key_prev = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_inv_key_sched.sv
// Decryption-side AES-128 key schedule: expands forward to K10 on a load, then
// steps backward one round key per request, with a one-cycle rewind to K10.
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] cipher_key,
  input  logic          key_load,
  input  logic          rkey_en,
  input  logic          rewind,
  output logic [KW-1:0] round_key_out,
  output logic [3:0]    round_num_out,
  output logic          key_ready,
  output logic          busy
);

  state_t        state, state_d;
  logic [KW-1:0] k10, k10_d;
  logic [KW-1:0] key_d, key_fwd, key_prev;
  logic [3:0]    num_d;
  logic          ready_d, busy_d;
  logic [31:0]   t, f0, f1, f2, f3;

  // Forward step toward round round_num_out + 1.
  always_comb begin
    t  = sub_word(rot_word(round_key_out[31:0])) ^ rcon(round_num_out + 4'd1);
    f0 = round_key_out[127:96] ^ t;
    f1 = round_key_out[95:64] ^ f0;
    f2 = round_key_out[63:32] ^ f1;
    f3 = round_key_out[31:0] ^ f2;
    key_fwd = {f0, f1, f2, f3};
  end

  aes_inv_round_key u_inv (
    .key_next (round_key_out),
    .round    (round_num_out),
    .key_prev (key_prev)
  );

  always_comb begin
    state_d = state;
    key_d   = round_key_out;
    num_d   = round_num_out;
    k10_d   = k10;
    if (key_load) begin
      state_d = EXPAND;
      key_d   = cipher_key;
      num_d   = 4'd0;
    end else begin
      case (state)
        EXPAND: begin
          key_d = key_fwd;
          num_d = round_num_out + 4'd1;
          if (round_num_out == 4'(NR - 1)) begin
            k10_d   = key_fwd;
            state_d = READY;
          end
        end
        READY: begin
          if (rewind) begin
            key_d = k10;
            num_d = 4'(NR);
          end else if (rkey_en && round_num_out != 4'd0) begin
            key_d = key_prev;
            num_d = round_num_out - 4'd1;
          end
        end
        default: ;
      endcase
    end
    ready_d = (state_d == READY);
    busy_d  = (state_d == EXPAND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      round_key_out <= '0;
      round_num_out <= '0;
      k10           <= '0;
      key_ready     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      round_key_out <= key_d;
      round_num_out <= num_d;
      k10           <= k10_d;
      key_ready     <= ready_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 key-schedule vectors and
// a queue of expected outputs compared one cycle after each stimulus step.
module tb_aes_inv_key_sched;

  localparam logic [127:0] KA0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KA1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KA9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KB0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB9  = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] KB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] cipher_key = '0;
  logic         key_load = 1'b0;
  logic         rkey_en = 1'b0;
  logic         rewind = 1'b0;
  logic [127:0] round_key_out;
  logic [3:0]   round_num_out;
  logic         key_ready;
  logic         busy;

  typedef struct {
    string        tag;
    logic         chk_key;
    logic [127:0] key;
    logic [3:0]   num;
    logic         ready;
    logic         bsy;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cipher_key    (cipher_key),
    .key_load      (key_load),
    .rkey_en       (rkey_en),
    .rewind        (rewind),
    .round_key_out (round_key_out),
    .round_num_out (round_num_out),
    .key_ready     (key_ready),
    .busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic chk_key, input logic [127:0] key,
                            input logic [3:0] num, input logic ready, input logic bsy);
    exp_t e;
    e.tag = tag; e.chk_key = chk_key; e.key = key; e.num = num; e.ready = ready; e.bsy = bsy;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (exp_q.size() != 0) passed++;
    else $error("FAIL scoreboard_empty got 0 entries required >=1");
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.chk_key) begin
        total++;
        assert (round_key_out === e.key) passed++;
        else $error("FAIL %s key got %h required %h", e.tag, round_key_out, e.key);
      end
      total++;
      assert (round_num_out === e.num) passed++;
      else $error("FAIL %s round got %0d required %0d", e.tag, round_num_out, e.num);
      total++;
      assert ({key_ready, busy} === {e.ready, e.bsy}) passed++;
      else $error("FAIL %s ready/busy got %b%b required %b%b", e.tag, key_ready, busy,
                  e.ready, e.bsy);
    end
  endtask

  // Load a key and run the expansion to READY, checking each cycle.
  task automatic load_and_expand(input logic [127:0] k, input logic [127:0] k10, input string tag);
    cipher_key = k;
    key_load = 1'b1;
    expect_out({tag, "_load"}, 1'b1, k, 4'd0, 1'b0, 1'b1);
    tick();
    key_load = 1'b0;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    check_out();
    for (int i = 1; i < 10; i++) begin
      expect_out({tag, "_expand"}, 1'b0, '0, 4'(i), 1'b0, 1'b1);
      tick();
      check_out();
    end
    expect_out({tag, "_k10"}, 1'b1, k10, 4'd10, 1'b1, 1'b0);
    tick();
    check_out();
  endtask

  initial begin
    // Reset state
    tick();
    expect_out("reset", 1'b1, '0, 4'd0, 1'b0, 1'b0);
    tick();
    check_out();
    rst_n = 1'b1;
    rkey_en = 1'b1;
    rewind = 1'b1;
    expect_out("idle_ignore", 1'b1, '0, 4'd0, 1'b0, 1'b0);
    tick();
    check_out();
    rkey_en = 1'b0;
    rewind = 1'b0;

    load_and_expand(KA0, KA10, "fips_a1");

    // Backward walk, back-to-back requests
    rkey_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 1)       expect_out("walk_k9", 1'b1, KA9, 4'd9, 1'b1, 1'b0);
      else if (i == 9)  expect_out("walk_k1", 1'b1, KA1, 4'd1, 1'b1, 1'b0);
      else if (i == 10) expect_out("walk_k0", 1'b1, KA0, 4'd0, 1'b1, 1'b0);
      else              expect_out("walk", 1'b0, '0, 4'(10 - i), 1'b1, 1'b0);
      tick();
      check_out();
    end
    for (int i = 0; i < 3; i++) begin
      expect_out("underflow", 1'b1, KA0, 4'd0, 1'b1, 1'b0);
      tick();
      check_out();
    end
    rkey_en = 1'b0;

    // Rewind from round 0, walk to round 4, then rewind together with rkey_en
    rewind = 1'b1;
    expect_out("rewind_r0", 1'b1, KA10, 4'd10, 1'b1, 1'b0);
    tick();
    check_out();
    rewind = 1'b0;
    rkey_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    expect_out("walk_r4", 1'b0, '0, 4'd4, 1'b1, 1'b0);
    check_out();
    rewind = 1'b1;
    expect_out("rewind_prio", 1'b1, KA10, 4'd10, 1'b1, 1'b0);
    tick();
    check_out();
    rewind = 1'b0;

    // key_load with rkey_en in READY, then a second key_load at expansion cycle 5
    cipher_key = KA0;
    key_load = 1'b1;
    expect_out("load_prio", 1'b1, KA0, 4'd0, 1'b0, 1'b1);
    tick();
    check_out();
    key_load = 1'b0;
    rkey_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    expect_out("mid_expand", 1'b0, '0, 4'd4, 1'b0, 1'b1);
    check_out();
    load_and_expand(KB0, KB10, "restart");
    rkey_en = 1'b1;
    expect_out("restart_k9", 1'b1, KB9, 4'd9, 1'b1, 1'b0);
    tick();
    check_out();
    rkey_en = 1'b0;
    rewind = 1'b1;
    expect_out("k10_overwritten", 1'b1, KB10, 4'd10, 1'b1, 1'b0);
    tick();
    check_out();
    rewind = 1'b0;

    // Asynchronous reset during EXPAND
    cipher_key = KA0;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    expect_out("rst_expand", 1'b1, '0, 4'd0, 1'b0, 1'b0);
    check_out();
    tick();
    rst_n = 1'b1;
    rkey_en = 1'b1;
    rewind = 1'b1;
    tick();
    expect_out("post_rst_ignore", 1'b1, '0, 4'd0, 1'b0, 1'b0);
    tick();
    check_out();
    rkey_en = 1'b0;
    rewind = 1'b0;

    // Asynchronous reset during READY
    load_and_expand(KA0, KA10, "reload");
    rkey_en = 1'b1;
    tick();
    rkey_en = 1'b0;
    rst_n = 1'b0;
    #1;
    expect_out("rst_ready", 1'b1, '0, 4'd0, 1'b0, 1'b0);
    check_out();
    tick();
    rst_n = 1'b1;
    rewind = 1'b1;
    expect_out("rst_ready_rewind", 1'b1, '0, 4'd0, 1'b0, 1'b0);
    tick();
    check_out();
    rewind = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
